// File: rtl/p_comp_pkg.sv
// Shared definitions for the p-bit computation path: FSM states and the
// signed input range of the p-bit.
package p_comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_e;

  localparam int FIELD_WIDTH = 4;
  localparam int FIELD_MIN   = -8;
  localparam int FIELD_MAX   = 7;

endpackage

// File: rtl/field_saturate.sv
// Combinational clamp of a signed accumulator value into the p-bit input
// range FIELD_MIN..FIELD_MAX.
module field_saturate
  import p_comp_pkg::*;
#(
  parameter int ACC_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0]   acc_in,
  output logic signed [FIELD_WIDTH-1:0] sat_out
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(FIELD_MAX);
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(FIELD_MIN);

  always_comb begin
    if (acc_in > MAX_V) begin
      sat_out = FIELD_WIDTH'(FIELD_MAX);
    end else if (acc_in < MIN_V) begin
      sat_out = FIELD_WIDTH'(FIELD_MIN);
    end else begin
      sat_out = acc_in[FIELD_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/p_local_field.sv
// Serial local-field accumulator I = h + sum(J_k * m_k), saturated to the
// p-bit input range. LOCAL_FIELD_SHIFT_EN adds a field_shift scale input.
module p_local_field
  import p_comp_pkg::*;
#(
  parameter int N_NEIGH   = 4,
  parameter int W_WIDTH   = 4,
  parameter int ACC_WIDTH = 8,
  localparam int AW       = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          w_we,
  input  logic [AW-1:0]                 w_addr,
  input  logic signed [W_WIDTH-1:0]     w_data,
  input  logic signed [W_WIDTH-1:0]     bias,
  input  logic [N_NEIGH-1:0]            spins,
  input  logic                          start,
`ifdef LOCAL_FIELD_SHIFT_EN
  input  logic [1:0]                    field_shift,
`endif
  output logic                          busy,
  output logic                          field_valid,
  output logic signed [FIELD_WIDTH-1:0] field_out
);

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic [N_NEIGH-1:0]          snap_q, snap_d;
  logic signed [W_WIDTH-1:0]   weight_q [N_NEIGH];
  logic signed [W_WIDTH-1:0]   weight_d [N_NEIGH];
  logic signed [FIELD_WIDTH-1:0] field_out_q, field_out_d;
  logic                        valid_q, valid_d;
  logic [1:0]                  shift_q, shift_d;

  logic [AW:0]                 addr_ext;
  logic signed [W_WIDTH-1:0]   cur_w;
  logic signed [ACC_WIDTH-1:0] cur_w_ext;
  logic signed [ACC_WIDTH-1:0] acc_shift;
  logic signed [FIELD_WIDTH-1:0] sat_val;

  assign addr_ext  = {1'b0, w_addr};
  assign cur_w     = weight_q[idx_q];
  assign cur_w_ext = {{(ACC_WIDTH-W_WIDTH){cur_w[W_WIDTH-1]}}, cur_w};
  assign acc_shift = acc_q >>> shift_q;

  field_saturate #(.ACC_WIDTH(ACC_WIDTH)) u_sat (
    .acc_in  (acc_shift),
    .sat_out (sat_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (idx_q == AW'(N_NEIGH-1)) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath next-state; weights only change while idle.
  always_comb begin
    acc_d       = acc_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    weight_d    = weight_q;
    field_out_d = field_out_q;
    valid_d     = 1'b0;
    shift_d     = shift_q;
    case (state_q)
      IDLE: begin
        if (w_we && (addr_ext < (AW+1)'(N_NEIGH))) begin
          weight_d[w_addr] = w_data;
        end
        if (start) begin
          snap_d = spins;
          acc_d  = {{(ACC_WIDTH-W_WIDTH){bias[W_WIDTH-1]}}, bias};
          idx_d  = '0;
`ifdef LOCAL_FIELD_SHIFT_EN
          shift_d = field_shift;
`else
          shift_d = 2'd0;
`endif
        end
      end
      ACCUM: begin
        acc_d = snap_q[idx_q] ? (acc_q + cur_w_ext) : (acc_q - cur_w_ext);
        idx_d = idx_q + AW'(1);
      end
      SAT: begin
        field_out_d = sat_val;
        valid_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      idx_q       <= '0;
      snap_q      <= '0;
      field_out_q <= '0;
      valid_q     <= 1'b0;
      shift_q     <= 2'd0;
      for (int i = 0; i < N_NEIGH; i++) weight_q[i] <= '0;
    end else begin
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      field_out_q <= field_out_d;
      valid_q     <= valid_d;
      shift_q     <= shift_d;
      weight_q    <= weight_d;
    end
  end

  assign field_valid = valid_q;
  assign field_out   = field_out_q;

endmodule

// File: tb/tb_p_local_field.sv
// Directed bench for p_local_field; covers LOCAL_FIELD_SHIFT_EN when defined.
module tb_p_local_field;

  logic              clk;
  logic              reset;
  logic              w_we;
  logic [1:0]        w_addr;
  logic signed [3:0] w_data;
  logic signed [3:0] bias;
  logic [3:0]        spins;
  logic              start;
  logic [1:0]        field_shift;
  logic              busy;
  logic              field_valid;
  logic signed [3:0] field_out;

  int n_cmp  = 0;
  int n_fail = 0;

  p_local_field dut (
    .clk         (clk),
    .reset       (reset),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .bias        (bias),
    .spins       (spins),
    .start       (start),
`ifdef LOCAL_FIELD_SHIFT_EN
    .field_shift (field_shift),
`endif
    .busy        (busy),
    .field_valid (field_valid),
    .field_out   (field_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_weights(input logic signed [3:0] j0, input logic signed [3:0] j1,
                               input logic signed [3:0] j2, input logic signed [3:0] j3);
    logic signed [3:0] js [4];
    js[0] = j0; js[1] = j1; js[2] = j2; js[3] = j3;
    for (int i = 0; i < 4; i++) begin
      w_we = 1'b1; w_addr = 2'(i); w_data = js[i];
      tick();
    end
    w_we = 1'b0;
  endtask

  // Starts a computation now and waits (bounded) for the valid pulse.
  task automatic run(input logic signed [3:0] b, input logic [3:0] s,
                     output logic [3:0] res, output int lat, output int busy_cnt);
    bias = b; spins = s; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1; busy_cnt = 0; res = 4'hx;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cnt++;
      if (field_valid) begin
        lat = i; res = field_out;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [3:0] res; int lat, bc;
    reset = 1'b0; start = 1'b1; w_we = 1'b1; w_addr = 2'd0; w_data = 4'sd5;
    bias = 4'sd2; spins = 4'b1111;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (field_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got=%b exp=0", field_valid); end
    n_cmp++; if (field_out !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_field got=%0d exp=0", field_out); end
    start = 1'b0; w_we = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run(4'sd3, 4'b1111, res, lat, bc);
    n_cmp++; if (res !== 4'd3) begin n_fail++; $display("[TB] FAIL reset_zero_weights got=%0d exp=3", $signed(res)); end
  endtask

  task automatic test_basic_sum();
    logic [3:0] res; int lat, bc;
    write_weights(4'sd3, -4'sd2, 4'sd1, 4'sd4);
    run(4'sd1, 4'b1011, res, lat, bc);
    n_cmp++; if (res !== 4'd5) begin n_fail++; $display("[TB] FAIL basic_field got=%0d exp=5", $signed(res)); end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("[TB] FAIL basic_latency got=%0d exp=5", lat); end
    n_cmp++; if (bc !== 5) begin n_fail++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=5", bc); end
    tick();
    n_cmp++; if (field_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_pulse_width got=%b exp=0", field_valid); end
    repeat (3) tick();
    n_cmp++; if (field_out !== 4'd5) begin n_fail++; $display("[TB] FAIL basic_hold got=%0d exp=5", field_out); end
  endtask

  task automatic test_saturation();
    logic [3:0] res; int lat, bc;
    write_weights(4'sd7, 4'sd7, 4'sd7, 4'sd7);
    run(4'sd7, 4'b1111, res, lat, bc);
    n_cmp++; if (res !== 4'd7) begin n_fail++; $display("[TB] FAIL sat_pos got=%0d exp=7", $signed(res)); end
    tick();
    run(-4'sd8, 4'b0000, res, lat, bc);
    n_cmp++; if (res !== 4'b1000) begin n_fail++; $display("[TB] FAIL sat_neg got=%0d exp=-8", $signed(res)); end
    tick();
  endtask

  task automatic test_most_negative();
    logic [3:0] res; int lat, bc;
    write_weights(-4'sd8, 4'sd0, 4'sd0, 4'sd0);
    run(4'sd0, 4'b0000, res, lat, bc);
    n_cmp++; if (res !== 4'd7) begin n_fail++; $display("[TB] FAIL neg_min_weight got=%0d exp=7", $signed(res)); end
    tick();
    run(4'sd0, 4'b0001, res, lat, bc);
    n_cmp++; if (res !== 4'b1000) begin n_fail++; $display("[TB] FAIL min_weight got=%0d exp=-8", $signed(res)); end
    tick();
  endtask

  task automatic test_protocol();
    logic [3:0] res; int lat, bc;
    write_weights(4'sd3, -4'sd2, 4'sd1, 4'sd4);
    bias = 4'sd1; spins = 4'b1011; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // Disturb everything while busy: restart, weight write, new bias/spins.
    start = 1'b1; w_we = 1'b1; w_addr = 2'd0; w_data = 4'sd7; bias = -4'sd8; spins = 4'b0000;
    tick();
    start = 1'b0; w_we = 1'b0;
    lat = -1;
    for (int i = 2; i < 20; i++) begin
      if (field_valid) begin lat = i; break; end
      tick();
    end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("[TB] FAIL busy_start_latency got=%0d exp=5", lat); end
    n_cmp++; if (field_out !== 4'd5) begin n_fail++; $display("[TB] FAIL busy_disturb got=%0d exp=5", field_out); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL no_restart got=%b exp=0", busy); end
    run(4'sd1, 4'b1011, res, lat, bc);
    n_cmp++; if (res !== 4'd5) begin n_fail++; $display("[TB] FAIL busy_write_dropped got=%0d exp=5", $signed(res)); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] res; int lat, bc;
    tick();
    run(4'sd1, 4'b1011, res, lat, bc);
    n_cmp++; if (res !== 4'd5) begin n_fail++; $display("[TB] FAIL b2b_first got=%0d exp=5", $signed(res)); end
    run(4'sd1, 4'b0000, res, lat, bc);
    n_cmp++; if (res !== 4'(-5)) begin n_fail++; $display("[TB] FAIL b2b_second got=%0d exp=-5", $signed(res)); end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("[TB] FAIL b2b_latency got=%0d exp=5", lat); end
    tick();
  endtask

  task automatic test_mid_reset();
    int seen;
    bias = 4'sd1; spins = 4'b1011; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    n_cmp++; if (field_out !== 4'd0) begin n_fail++; $display("[TB] FAIL midreset_field got=%0d exp=0", field_out); end
    tick();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (field_valid) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_valid got=%0d exp=0", seen); end
  endtask

`ifdef LOCAL_FIELD_SHIFT_EN
  task automatic test_shift();
    logic [3:0] res; int lat, bc;
    write_weights(4'sd3, -4'sd2, 4'sd1, 4'sd4);
    field_shift = 2'd2;
    run(4'sd1, 4'b1011, res, lat, bc);
    field_shift = 2'd0;
    n_cmp++; if (res !== 4'd1) begin n_fail++; $display("[TB] FAIL shift_field got=%0d exp=1", $signed(res)); end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    bias = '0; spins = '0; start = 1'b0; field_shift = 2'd0;
    test_reset();
    test_basic_sum();
    test_saturation();
    test_most_negative();
    test_protocol();
    test_back_to_back();
    test_mid_reset();
`ifdef LOCAL_FIELD_SHIFT_EN
    test_shift();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
